// File: rtl/tick_pkg.sv
// -----------------------------------------------------------------------------
// tick_pkg
//   Shared types and helpers for the multi-channel tick divider.
//   - ch_state_t    : per-channel run state (IDLE / RUN / DONE)
//   - CNT_W_DEFAULT : default counter/divisor width (covers 12 MHz -> 1 Hz)
//   - hz_to_div()   : divisor that turns clk_hz into a tick_hz pulse train
// -----------------------------------------------------------------------------
package tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // paused, counter held
        RUN  = 2'd1,    // counting
        DONE = 2'd2     // one-shot expired, waits for clr
    } ch_state_t;

    localparam int CNT_W_DEFAULT = 24;

    // Divisor for a tick rate of tick_hz from a clk_hz clock.
    // A zero target rate yields 0, which the config path rejects.
    function automatic int unsigned hz_to_div(input int unsigned clk_hz,
                                              input int unsigned tick_hz);
        if (tick_hz == 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
//   One tick channel: up-counter, active divisor/mode, shadow (pending) config
//   and the IDLE/RUN/DONE state machine.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : run enable (low = pause, counter held)
//   clr          : synchronous restart, applies any pending config
//   cfg_we       : validated write strobe already decoded for this channel
//   cfg_div      : new divisor (never 0 here)
//   cfg_oneshot  : new mode, 1 = one-shot
//   tick         : registered 1-cycle pulse on each wrap
//   busy         : registered, high while in RUN
// -----------------------------------------------------------------------------
module tick_channel
    import tick_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 12_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    output logic             tick,
    output logic             busy
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             oneshot_q, oneshot_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_oneshot_q, pend_oneshot_d;
    logic             pend_valid_q, pend_valid_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;

    // A write arriving this cycle supersedes anything still pending, so every
    // apply point below uses these merged values.
    logic             new_valid;
    logic [CNT_W-1:0] new_div;
    logic             new_oneshot;
    logic             at_wrap;
    logic             counting;

    assign new_valid   = cfg_we | pend_valid_q;
    assign new_div     = cfg_we ? cfg_div : pend_div_q;
    assign new_oneshot = cfg_we ? cfg_oneshot : pend_oneshot_q;
    assign at_wrap     = (cnt_q == div_q - CNT_W'(1));
    // Counting is gated by en directly, so the edge that leaves IDLE already
    // counts and a period is exactly div enabled edges.
    assign counting    = en && (state_q != DONE);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        div_d          = div_q;
        oneshot_d      = oneshot_q;
        pend_div_d     = pend_div_q;
        pend_oneshot_d = pend_oneshot_q;
        pend_valid_d   = pend_valid_q;
        tick_d         = 1'b0;

        if (clr) begin
            // Restart wins over wrap: no tick on this edge.
            cnt_d   = '0;
            state_d = en ? RUN : IDLE;
            if (new_valid) begin
                div_d        = new_div;
                oneshot_d    = new_oneshot;
                pend_valid_d = 1'b0;
            end
        end else if ((state_q != RUN) && new_valid) begin
            // Not mid-period: apply at once and restart the phase, so a held
            // count can never sit above a smaller new divisor.
            cnt_d        = '0;
            div_d        = new_div;
            oneshot_d    = new_oneshot;
            pend_valid_d = 1'b0;
            if ((state_q == IDLE) && en) begin
                state_d = RUN;
            end
        end else begin
            if (cfg_we) begin
                pend_div_d     = cfg_div;
                pend_oneshot_d = cfg_oneshot;
                pend_valid_d   = 1'b1;
            end
            if (counting) begin
                if (at_wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    // Period boundary: the only safe point to swap divisors.
                    if (new_valid) begin
                        div_d        = new_div;
                        oneshot_d    = new_oneshot;
                        pend_valid_d = 1'b0;
                    end
                    state_d = oneshot_q ? DONE : RUN;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = RUN;
                end
            end else if (state_q == RUN) begin
                state_d = IDLE;
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            div_q          <= CNT_W'(DEFAULT_DIV);
            oneshot_q      <= 1'b0;
            pend_div_q     <= '0;
            pend_oneshot_q <= 1'b0;
            pend_valid_q   <= 1'b0;
            tick_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            oneshot_q      <= oneshot_d;
            pend_div_q     <= pend_div_d;
            pend_oneshot_q <= pend_oneshot_d;
            pend_valid_q   <= pend_valid_d;
            tick_q         <= tick_d;
            busy_q         <= busy_d;
        end
    end

    assign tick = tick_q;
    assign busy = busy_q;

endmodule

// File: rtl/tick_divider_multi.sv
// -----------------------------------------------------------------------------
// tick_divider_multi
//   NUM_CH independent tick channels, each dividing clk by a runtime divisor.
//   This level decodes and validates configuration writes and registers the
//   cfg_err pulse; the channels do the counting.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   en[NUM_CH]   : per-channel run enable
//   clr[NUM_CH]  : per-channel synchronous restart
//   cfg_we       : divisor/mode write strobe
//   cfg_ch       : target channel; one code wider than the channel count so
//                  that out-of-range indices reach the error check
//   cfg_div      : new divisor, period = cfg_div cycles (0 is rejected)
//   cfg_oneshot  : 1 = one-shot, 0 = periodic
//   tick[NUM_CH] : registered 1-cycle tick pulses
//   busy[NUM_CH] : registered, channel in RUN
//   cfg_err      : registered 1-cycle pulse when a write is rejected
// -----------------------------------------------------------------------------
module tick_divider_multi
    import tick_pkg::*;
#(
    parameter int CLK_HZ      = 12_000_000,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = int'(hz_to_div(CLK_HZ, 1)),
    localparam int CH_W       = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy,
    output logic              cfg_err
);

    logic cfg_bad;
    logic cfg_err_q, cfg_err_d;

    always_comb begin
        cfg_bad   = (cfg_div == '0) || (cfg_ch >= CH_W'(NUM_CH));
        cfg_err_d = cfg_we && cfg_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic ch_we;
            assign ch_we = cfg_we && !cfg_bad && (cfg_ch == CH_W'(gi));

            tick_channel #(
                .CNT_W      (CNT_W),
                .DEFAULT_DIV(DEFAULT_DIV)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (en[gi]),
                .clr        (clr[gi]),
                .cfg_we     (ch_we),
                .cfg_div    (cfg_div),
                .cfg_oneshot(cfg_oneshot),
                .tick       (tick[gi]),
                .busy       (busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tick_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_tick_divider_multi
//   Directed stimulus with hand-computed tick/cfg_err edge numbers pushed into
//   scoreboard queues; a negedge monitor pops and compares each observed pulse
//   and flags any expected pulse that is overdue.
// -----------------------------------------------------------------------------
module tb_tick_divider_multi;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic [NCH-1:0] clr;
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_oneshot;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;
    logic           cfg_err;

    tick_divider_multi #(
        .CLK_HZ     (12),
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .DEFAULT_DIV(12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_oneshot(cfg_oneshot),
        .tick       (tick),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge is the number of posedges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int edge_no;
    } ev_t;

    ev_t tick_exp[$];
    int  err_exp[$];
    int  checks   = 0;
    int  failures = 0;
    ev_t mon_ev;
    int  mon_err;

    task automatic exp_tick(input int ch, input int e);
        ev_t v;
        v.ch      = ch;
        v.edge_no = e;
        tick_exp.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end else begin
            $display("check %s = %b ok", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every pulse against the scoreboard heads.
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (tick[ch] === 1'b1) begin
                checks++;
                if (tick_exp.size() == 0) begin
                    failures++;
                    $display("FAIL tick_unexpected: ch=%0d at edge %0d, none required", ch, cyc);
                end else begin
                    mon_ev = tick_exp.pop_front();
                    if (mon_ev.ch != ch || mon_ev.edge_no != cyc) begin
                        failures++;
                        $display("FAIL tick_match: got ch=%0d edge=%0d required ch=%0d edge=%0d",
                                 ch, cyc, mon_ev.ch, mon_ev.edge_no);
                    end else begin
                        $display("tick ch=%0d edge=%0d ok", ch, cyc);
                    end
                end
            end
        end
        if (tick_exp.size() != 0 && tick_exp[0].edge_no < cyc) begin
            mon_ev = tick_exp.pop_front();
            checks++;
            failures++;
            $display("FAIL tick_missing: got none by edge %0d required ch=%0d edge=%0d",
                     cyc, mon_ev.ch, mon_ev.edge_no);
        end
        if (cfg_err === 1'b1) begin
            checks++;
            if (err_exp.size() == 0) begin
                failures++;
                $display("FAIL cfg_err_unexpected: got pulse at edge %0d, none required", cyc);
            end else begin
                mon_err = err_exp.pop_front();
                if (mon_err != cyc) begin
                    failures++;
                    $display("FAIL cfg_err_match: got edge %0d required edge %0d", cyc, mon_err);
                end else begin
                    $display("cfg_err edge=%0d ok", cyc);
                end
            end
        end
        if (err_exp.size() != 0 && err_exp[0] < cyc) begin
            mon_err = err_exp.pop_front();
            checks++;
            failures++;
            $display("FAIL cfg_err_missing: got none by edge %0d required edge %0d", cyc, mon_err);
        end
    end

    int b, c, d, e, f, r;

    initial begin
        rst_n       = 1'b0;
        en          = '0;
        clr         = '0;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        cfg_oneshot = 1'b0;

        step(3);
        check("rst_tick", tick, 4'b0000);
        check("rst_busy", busy, 4'b0000);
        check("rst_cfg_err", {3'b000, cfg_err}, 4'b0000);
        rst_n = 1'b1;
        step(2);

        // ch0 default divisor 12, then pause at count 7 for 20 cycles.
        b = cyc;
        en = 4'b0001;
        exp_tick(0, b + 12);
        exp_tick(0, b + 24);
        exp_tick(0, b + 36);
        exp_tick(0, b + 68);
        wait_until(b + 2);
        check("busy_ch0_run", busy, 4'b0001);
        wait_until(b + 43);
        en = 4'b0000;
        wait_until(b + 45);
        check("busy_ch0_paused", busy, 4'b0000);
        wait_until(b + 63);
        en = 4'b0001;
        wait_until(b + 70);
        en = 4'b0000;                       // ch0 held at count 2

        // ch1 div=5, then rewrite (9 then 3) mid-period.
        step(2);
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5; cfg_oneshot = 1'b0;
        step(1);
        cfg_we = 1'b0;
        en = 4'b0010;
        c = cyc;
        exp_tick(1, c + 5);
        exp_tick(1, c + 10);
        exp_tick(1, c + 15);
        exp_tick(1, c + 18);
        exp_tick(1, c + 21);
        wait_until(c + 12);
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd9;
        step(1);
        cfg_div = 8'd3;
        step(1);
        cfg_we = 1'b0;
        wait_until(c + 22);
        en = 4'b0000;                       // ch1 held at count 1

        // ch2 one-shot div=4, restart via clr.
        step(2);
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd4; cfg_oneshot = 1'b1;
        en = 4'b0100;
        step(1);
        cfg_we = 1'b0; cfg_oneshot = 1'b0;
        d = cyc;
        exp_tick(2, d + 4);
        wait_until(d + 2);
        check("busy_ch2_run", busy, 4'b0100);
        wait_until(d + 6);
        check("busy_ch2_done", busy, 4'b0000);
        wait_until(d + 10);
        clr = 4'b0100;
        exp_tick(2, d + 15);
        step(1);
        clr = 4'b0000;
        wait_until(d + 13);
        check("busy_ch2_restart", busy, 4'b0100);
        wait_until(d + 17);
        check("busy_ch2_done2", busy, 4'b0000);
        en = 4'b0000;

        // Rejected writes: div=0, then channel 5.
        step(2);
        e = cyc;
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd0;
        err_exp.push_back(e + 1);
        step(1);
        cfg_ch = 3'd5; cfg_div = 8'd2;
        err_exp.push_back(e + 2);
        step(1);
        cfg_we = 1'b0;
        step(2);
        e = cyc;
        en = 4'b0010;                       // ch1 resumes from 1 with div 3
        exp_tick(1, e + 2);
        exp_tick(1, e + 5);
        exp_tick(1, e + 8);
        wait_until(e + 9);
        en = 4'b0000;

        // ch0 resumes from count 2, then async reset mid-count.
        step(2);
        f = cyc;
        en = 4'b0001;
        exp_tick(0, f + 10);
        wait_until(f + 12);
        check("busy_ch0_before_rst", busy, 4'b0001);
        wait_until(f + 13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tick", tick, 4'b0000);
        check("async_rst_busy", busy, 4'b0000);
        check("async_rst_cfg_err", {3'b000, cfg_err}, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r = cyc;
        exp_tick(0, r + 12);
        exp_tick(0, r + 24);
        wait_until(r + 27);

        checks++;
        if (tick_exp.size() + err_exp.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d events left required 0",
                     tick_exp.size() + err_exp.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
